// File: rtl/datamem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported 16-bit data memory.
// One access in flight at a time; read data returned after a fixed latency.
module datamem_arbiter #(
   parameter int LAT   = 2,
   parameter int FIXED = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [15:0] p0_addr,
   input  logic [15:0] p0_wdata,
   output logic        p0_gnt,
   output logic        p0_done,
   output logic [15:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [15:0] p1_addr,
   input  logic [15:0] p1_wdata,
   output logic        p1_gnt,
   output logic        p1_done,
   output logic [15:0] p1_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        busy
);
   // state | meaning
   // IDLE  | arbitrating; grant is combinational from the requests
   // ISSUE | memory strobe driven from the latched command
   // WAIT  | counting down the read latency
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   localparam logic [3:0] LAT_C = 4'(LAT);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        rr_q, rr_d;
   logic        owner_q, owner_d;
   logic        cmd_we_q, cmd_we_d;
   logic [15:0] cmd_addr_q, cmd_addr_d;
   logic [15:0] cmd_wdata_q, cmd_wdata_d;
   logic        p0_done_q, p0_done_d;
   logic        p1_done_q, p1_done_d;
   logic [15:0] p0_rdata_q, p0_rdata_d;
   logic [15:0] p1_rdata_q, p1_rdata_d;
   logic        win1;
   logic        gnt0;
   logic        gnt1;

   // rr_q=1 means port 1 is preferred on a tie
   always_comb begin
      win1 = 1'b0;
      if (p1_req && !p0_req) begin
         win1 = 1'b1;
      end else if (p1_req && p0_req && (FIXED == 0)) begin
         win1 = rr_q;
      end
   end

   // Gated by reset so every output is quiet while reset is held
   assign gnt0 = reset && (state_q == IDLE) && p0_req && !win1;
   assign gnt1 = reset && (state_q == IDLE) && p1_req && win1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rr_d        = rr_q;
      owner_d     = owner_q;
      cmd_we_d    = cmd_we_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      p0_done_d   = 1'b0;
      p1_done_d   = 1'b0;
      p0_rdata_d  = p0_rdata_q;
      p1_rdata_d  = p1_rdata_q;
      unique case (state_q)
         IDLE: begin
            if (gnt0 || gnt1) begin
               state_d     = ISSUE;
               owner_d     = gnt1;
               cmd_we_d    = gnt1 ? p1_we    : p0_we;
               cmd_addr_d  = gnt1 ? p1_addr  : p0_addr;
               cmd_wdata_d = gnt1 ? p1_wdata : p0_wdata;
               if (FIXED == 0) begin
                  rr_d = gnt0;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
            cnt_d   = LAT_C;
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = IDLE;
               if (!cmd_we_q) begin
                  if (owner_q) begin
                     p1_rdata_d = mem_rdata;
                  end else begin
                     p0_rdata_d = mem_rdata;
                  end
               end
               p0_done_d = !owner_q;
               p1_done_d = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         rr_q        <= 1'b0;
         owner_q     <= 1'b0;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= 16'h0000;
         cmd_wdata_q <= 16'h0000;
         p0_done_q   <= 1'b0;
         p1_done_q   <= 1'b0;
         p0_rdata_q  <= 16'h0000;
         p1_rdata_q  <= 16'h0000;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rr_q        <= rr_d;
         owner_q     <= owner_d;
         cmd_we_q    <= cmd_we_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         p0_done_q   <= p0_done_d;
         p1_done_q   <= p1_done_d;
         p0_rdata_q  <= p0_rdata_d;
         p1_rdata_q  <= p1_rdata_d;
      end
   end

   assign p0_gnt    = gnt0;
   assign p1_gnt    = gnt1;
   assign p0_done   = p0_done_q;
   assign p1_done   = p1_done_q;
   assign p0_rdata  = p0_rdata_q;
   assign p1_rdata  = p1_rdata_q;
   assign mem_en    = (state_q == ISSUE);
   assign mem_we    = (state_q == ISSUE) && cmd_we_q;
   assign mem_addr  = cmd_addr_q;
   assign mem_wdata = cmd_wdata_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: three instances (LAT2 round-robin, LAT2 fixed,
// LAT1 round-robin), each with its own memory model and a shared scoreboard.
`timescale 1ns/1ps
module tb_datamem_arbiter;
   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        p0_req [NI];
   logic        p0_we [NI];
   logic [15:0] p0_addr [NI];
   logic [15:0] p0_wdata [NI];
   logic        p0_gnt [NI];
   logic        p0_done [NI];
   logic [15:0] p0_rdata [NI];
   logic        p1_req [NI];
   logic        p1_we [NI];
   logic [15:0] p1_addr [NI];
   logic [15:0] p1_wdata [NI];
   logic        p1_gnt [NI];
   logic        p1_done [NI];
   logic [15:0] p1_rdata [NI];
   logic        mem_en [NI];
   logic        mem_we [NI];
   logic [15:0] mem_addr [NI];
   logic [15:0] mem_wdata [NI];
   logic        busy [NI];

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          inst;
      int          port;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
   } vec_t;

   typedef struct {
      int          inst;
      int          port;
      int          cyc;
      logic [15:0] rd;
   } exp_t;

   exp_t        sbq [$];
   int          exp_en_cyc [NI];
   logic        exp_we [NI];
   logic [15:0] exp_addr [NI];
   logic [15:0] exp_wd [NI];
   logic [15:0] smem [NI][256];
   logic [15:0] last_rd [NI][2];

   function automatic int lat_of(input int g);
      return (g == 2) ? 1 : 2;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int L = (g == 2) ? 1 : 2;
      localparam int F = (g == 1) ? 1 : 0;
      logic [15:0] mem [256];
      logic [15:0] pipe_d [L];
      logic        pipe_v [L];
      logic [15:0] rdata_w;

      datamem_arbiter #(.LAT(L), .FIXED(F)) u_dut (
         .clk       (clk),
         .reset     (reset),
         .p0_req    (p0_req[g]),
         .p0_we     (p0_we[g]),
         .p0_addr   (p0_addr[g]),
         .p0_wdata  (p0_wdata[g]),
         .p0_gnt    (p0_gnt[g]),
         .p0_done   (p0_done[g]),
         .p0_rdata  (p0_rdata[g]),
         .p1_req    (p1_req[g]),
         .p1_we     (p1_we[g]),
         .p1_addr   (p1_addr[g]),
         .p1_wdata  (p1_wdata[g]),
         .p1_gnt    (p1_gnt[g]),
         .p1_done   (p1_done[g]),
         .p1_rdata  (p1_rdata[g]),
         .mem_en    (mem_en[g]),
         .mem_we    (mem_we[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_rdata (rdata_w),
         .busy      (busy[g])
      );

      // Read data is valid only in the single cycle LAT after the strobe
      always @(posedge clk) begin
         if (mem_en[g] && mem_we[g]) mem[mem_addr[g][7:0]] <= mem_wdata[g];
         pipe_v[0] <= mem_en[g] && !mem_we[g];
         pipe_d[0] <= mem[mem_addr[g][7:0]];
         for (int k = 1; k < L; k++) begin
            pipe_v[k] <= pipe_v[k-1];
            pipe_d[k] <= pipe_d[k-1];
         end
      end
      assign rdata_w = pipe_v[L-1] ? pipe_d[L-1] : 16'hDEAD;
   end

   // Scoreboard: expectations pushed on grant, popped on done
   always @(negedge clk) begin
      logic [1:0] dn;
      logic [1:0] gn;
      logic       busy_exp;
      int         lat;
      exp_t       e;
      if (!reset) begin
         sbq.delete();
         for (int g = 0; g < NI; g++) begin
            exp_en_cyc[g] = -100;
            last_rd[g][0] = 16'h0000;
            last_rd[g][1] = 16'h0000;
         end
      end else begin
         for (int g = 0; g < NI; g++) begin
            lat = lat_of(g);
            dn  = {p1_done[g], p0_done[g]};
            gn  = {p1_gnt[g], p0_gnt[g]};
            for (int p = 0; p < 2; p++) begin
               if (dn[p]) begin
                  if (sbq.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL spurious_done: inst %0d port %0d got done, expected none (cycle %0d)", g, p, cyc);
                  end else begin
                     e = sbq.pop_front();
                     chk("done_inst", g, e.inst);
                     chk("done_port", p, e.port);
                     chk("done_cycle", cyc, e.cyc);
                     chk("done_rdata", (p == 0) ? p0_rdata[g] : p1_rdata[g], e.rd);
                  end
               end
            end
            chk("mem_en", mem_en[g], cyc == exp_en_cyc[g]);
            if (mem_en[g]) begin
               chk("mem_we", mem_we[g], exp_we[g]);
               chk("mem_addr", mem_addr[g], exp_addr[g]);
               chk("mem_wdata", mem_wdata[g], exp_wd[g]);
            end else begin
               chk("mem_we_idle", mem_we[g], 1'b0);
            end
            busy_exp = (cyc >= exp_en_cyc[g]) && (cyc <= exp_en_cyc[g] + lat);
            chk("busy", busy[g], busy_exp);
            chk("gnt_exclusive", gn == 2'b11, 1'b0);
            chk("gnt_when_busy", (gn != 2'b00) && busy_exp, 1'b0);
            for (int p = 0; p < 2; p++) begin
               if (gn[p]) begin
                  if (p == 0) begin
                     exp_we[g] = p0_we[g]; exp_addr[g] = p0_addr[g]; exp_wd[g] = p0_wdata[g];
                  end else begin
                     exp_we[g] = p1_we[g]; exp_addr[g] = p1_addr[g]; exp_wd[g] = p1_wdata[g];
                  end
                  e.inst = g;
                  e.port = p;
                  e.cyc  = cyc + 2 + lat;
                  if (exp_we[g]) begin
                     smem[g][exp_addr[g][7:0]] = exp_wd[g];
                     e.rd = last_rd[g][p];
                  end else begin
                     e.rd = smem[g][exp_addr[g][7:0]];
                     last_rd[g][p] = e.rd;
                  end
                  sbq.push_back(e);
                  exp_en_cyc[g] = cyc + 1;
               end
            end
         end
      end
   end

   task automatic cyc_begin();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int g, input int p, input logic rq, input logic we,
                        input logic [15:0] a, input logic [15:0] d);
      if (p == 0) begin
         p0_req[g] = rq; p0_we[g] = we; p0_addr[g] = a; p0_wdata[g] = d;
      end else begin
         p1_req[g] = rq; p1_we[g] = we; p1_addr[g] = a; p1_wdata[g] = d;
      end
   endtask

   function automatic logic gnt_of(input int g, input int p);
      return (p == 0) ? p0_gnt[g] : p1_gnt[g];
   endfunction

   function automatic logic done_of(input int g, input int p);
      return (p == 0) ? p0_done[g] : p1_done[g];
   endfunction

   function automatic logic [15:0] rdata_of(input int g, input int p);
      return (p == 0) ? p0_rdata[g] : p1_rdata[g];
   endfunction

   task automatic chk_rst_outputs(input int g);
      chk("rst_p0_gnt", p0_gnt[g], 1'b0);
      chk("rst_p1_gnt", p1_gnt[g], 1'b0);
      chk("rst_p0_done", p0_done[g], 1'b0);
      chk("rst_p1_done", p1_done[g], 1'b0);
      chk("rst_p0_rdata", p0_rdata[g], 16'h0000);
      chk("rst_p1_rdata", p1_rdata[g], 16'h0000);
      chk("rst_mem_en", mem_en[g], 1'b0);
      chk("rst_mem_we", mem_we[g], 1'b0);
      chk("rst_mem_addr", mem_addr[g], 16'h0000);
      chk("rst_mem_wdata", mem_wdata[g], 16'h0000);
      chk("rst_busy", busy[g], 1'b0);
   endtask

   // Single request to an idle arbiter; fields are scrambled after grant
   task automatic do_txn(input vec_t v);
      int gc;
      int dc;
      bit got;
      cyc_begin();
      drive(v.inst, v.port, 1'b1, v.we, v.addr, v.wdata);
      @(negedge clk);
      chk("txn_gnt", gnt_of(v.inst, v.port), 1'b1);
      gc = cyc;
      cyc_begin();
      drive(v.inst, v.port, 1'b0, !v.we, ~v.addr, ~v.wdata);
      got = 0;
      dc  = 0;
      for (int k = 0; k < 24 && !got; k++) begin
         @(negedge clk);
         if (done_of(v.inst, v.port)) begin
            got = 1;
            dc  = cyc;
         end
      end
      chk("txn_done_seen", got, 1'b1);
      chk("txn_done_latency", dc - gc, 2 + lat_of(v.inst));
      chk("txn_rdata", rdata_of(v.inst, v.port), v.exp_rd);
   endtask

   task automatic drain(input string nm);
      int k;
      k = 0;
      while (sbq.size() != 0 && k < 30) begin
         @(negedge clk);
         k++;
      end
      chk(nm, sbq.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt [11];
      vec_t v;
      vt[0]  = '{0, 1, 1'b1, 16'h0010, 16'h1234, 16'h0000};
      vt[1]  = '{0, 0, 1'b0, 16'h0010, 16'h0000, 16'h1234};
      vt[2]  = '{0, 1, 1'b1, 16'h0001, 16'hBEEF, 16'h0000};
      vt[3]  = '{0, 1, 1'b0, 16'h0001, 16'h0000, 16'hBEEF};
      vt[4]  = '{0, 0, 1'b1, 16'h0020, 16'h5A5A, 16'h1234};
      vt[5]  = '{0, 0, 1'b0, 16'h0020, 16'h0000, 16'h5A5A};
      vt[6]  = '{0, 1, 1'b0, 16'h0010, 16'h0000, 16'h1234};
      vt[7]  = '{1, 0, 1'b1, 16'h0005, 16'h1111, 16'h0000};
      vt[8]  = '{1, 1, 1'b0, 16'h0005, 16'h0000, 16'h1111};
      vt[9]  = '{2, 1, 1'b1, 16'h0007, 16'h7777, 16'h0000};
      vt[10] = '{2, 0, 1'b0, 16'h0007, 16'h0000, 16'h7777};

      reset = 1'b0;
      for (int g = 0; g < NI; g++) begin
         drive(g, 0, 1'b0, 1'b0, 16'h0000, 16'h0000);
         drive(g, 1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < NI; g++) chk_rst_outputs(g);
      cyc_begin();
      reset = 1'b1;

      foreach (vt[i]) do_txn(vt[i]);

      // Store then a held load on port 1: second grant on the store's done cycle
      cyc_begin();
      drive(0, 1, 1'b1, 1'b1, 16'h0001, 16'hC0DE);
      @(negedge clk);
      chk("b2b_gnt_store", p1_gnt[0], 1'b1);
      for (int k = 1; k <= 8; k++) begin
         cyc_begin();
         if (k == 1) drive(0, 1, 1'b1, 1'b0, 16'h0001, 16'h0000);
         if (k == 5) p1_req[0] = 1'b0;
         @(negedge clk);
         chk("b2b_p1_gnt", p1_gnt[0], k == 4);
         chk("b2b_p1_done", p1_done[0], (k == 4) || (k == 8));
      end
      chk("b2b_load_rdata", p1_rdata[0], 16'hC0DE);

      // Last grant to port 0, so only reset can make port 0 win the next tie
      v = '{0, 0, 1'b0, 16'h0020, 16'h0000, 16'h5A5A};
      do_txn(v);

      cyc_begin();
      reset = 1'b0;
      cyc_begin();
      reset = 1'b1;
      drive(0, 0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      drive(0, 1, 1'b1, 1'b0, 16'h0001, 16'h0000);
      for (int k = 0; k <= 12; k++) begin
         @(negedge clk);
         chk("rr_p0_gnt", p0_gnt[0], (k == 0) || (k == 8));
         chk("rr_p1_gnt", p1_gnt[0], (k == 4) || (k == 12));
         chk("rr_p0_done", p0_done[0], (k == 4) || (k == 12));
         chk("rr_p1_done", p1_done[0], k == 8);
      end
      cyc_begin();
      p0_req[0] = 1'b0;
      p1_req[0] = 1'b0;
      drain("rr_drain");

      // Reset asserted during WAIT of a port-0 load
      cyc_begin();
      drive(0, 0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      @(negedge clk);
      chk("rw_gnt", p0_gnt[0], 1'b1);
      cyc_begin();
      p0_req[0] = 1'b0;
      @(negedge clk);
      chk("rw_mem_en", mem_en[0], 1'b1);
      cyc_begin();
      reset = 1'b0;
      @(negedge clk);
      chk("rw_busy_wait", busy[0], 1'b1);
      cyc_begin();
      reset = 1'b1;
      @(negedge clk);
      chk_rst_outputs(0);
      cyc_begin();
      @(negedge clk);
      chk("rw_no_done", p0_done[0], 1'b0);
      v = '{0, 1, 1'b0, 16'h0001, 16'h0000, 16'hC0DE};
      do_txn(v);

      // Fixed priority: port 1 starves until port 0 drops its request
      cyc_begin();
      drive(1, 0, 1'b1, 1'b0, 16'h0005, 16'h0000);
      drive(1, 1, 1'b1, 1'b0, 16'h0005, 16'h0000);
      for (int k = 0; k <= 24; k++) begin
         @(negedge clk);
         chk("fix_p0_gnt", p0_gnt[1], ((k % 4) == 0) && (k <= 20));
         chk("fix_p1_gnt", p1_gnt[1], k == 24);
         if (k == 20) begin
            cyc_begin();
            p0_req[1] = 1'b0;
         end
      end
      cyc_begin();
      p1_req[1] = 1'b0;
      drain("fix_drain");
      chk("fix_p1_rdata", p1_rdata[1], 16'h1111);

      // LAT=1: request dropped right after grant still completes
      v = '{2, 1, 1'b1, 16'h0007, 16'h8888, 16'h0000};
      do_txn(v);
      cyc_begin();
      drive(2, 0, 1'b1, 1'b0, 16'h0007, 16'h0000);
      @(negedge clk);
      chk("l1_gnt", p0_gnt[2], 1'b1);
      for (int k = 1; k <= 3; k++) begin
         cyc_begin();
         if (k == 1) p0_req[2] = 1'b0;
         @(negedge clk);
         chk("l1_mem_en", mem_en[2], k == 1);
         chk("l1_busy", busy[2], k <= 2);
         chk("l1_done", p0_done[2], k == 3);
      end
      chk("l1_rdata", p0_rdata[2], 16'h8888);

      drain("final_drain");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
